toggle_event_rx: RTL and testbench
==================================

Name: toggle_event_rx

Overview:
- Receive side of the toggle-flop event link. The sender flips a T flip-flop once per event; this block recovers one event per level change.
- Resynchronises the toggle line, emits a one-cycle pulse per change, and queues events as a saturating pending count drained over a valid/ready handshake.
- Keeps a wrapping total-event counter and a sticky overflow flag.
- Sits directly downstream of the T_FF output q.

Parameters:
SYNC_STAGES, 2, depth of input resynchroniser chain (legal 1..4)
PEND_W, 3, width of pending-event counter; max pending = 2**PEND_W-1
CNT_W, 8, width of total-event counter

Ports:
clk  input  1  rising-edge clock, single domain
reset  input  1  synchronous, active-low reset; sampled on rising clk
tgl_in  input  1  toggle line from the sender's T flip-flop
evt_pulse  output  1  one-cycle pulse per detected toggle
evt_valid  output  1  at least one event pending
evt_ready  input  1  consumer accepts one event when high with evt_valid
pend_cnt  output  PEND_W  number of pending events
evt_total  output  CNT_W  total events detected since reset, wraps
overflow  output  1  sticky: an event was dropped because the queue was full
clr_ovf  input  1  clears overflow

Behaviour:
- Reset (reset==0 at a rising clk):
  - Every sync stage and the previous-value register load the current tgl_in, so no spurious event appears after reset.
  - evt_pulse=0, pend_cnt=0, evt_valid=0, evt_total=0, overflow=0.
  - Reset asserted mid-operation discards pending events immediately. It takes priority over all other inputs.
- Sync chain: tgl_in passes through SYNC_STAGES flops to give s. The prev register holds s from the previous cycle.
- Detect: evt_pulse is registered as s^prev.
  - A tgl_in change first captured at edge n makes evt_pulse high for exactly one cycle, beginning after edge n+SYNC_STAGES.
  - Each level change yields exactly one pulse. Changes shorter than one clock may be lost; this is by design and no detection is required.
- Pending counter (updates on the edge where evt_pulse==1 and/or pop):
  - pop = evt_valid & evt_ready.
  - inc only: pend_cnt+1.
  - pop only: pend_cnt-1.
  - inc and pop together: unchanged.
  - inc at max without pop: pend_cnt stays at max, overflow set.
  - inc at max with pop: unchanged, no overflow.
  - pop at 0 is impossible, because evt_valid=0 there.
- evt_valid = (pend_cnt!=0), driven combinationally from the register. evt_ready is ignored while evt_valid=0.
- Latency: a toggle captured at edge n is visible on pend_cnt/evt_valid after edge n+SYNC_STAGES+1.
- evt_total: increments on every edge where evt_pulse==1, dropped events included. Wraps 2**CNT_W-1 -> 0, with no flag.
- overflow: sticky until clr_ovf==1 at an edge. If a set and a clear coincide, set wins.
- All outputs are registered except evt_valid.

Decomposition:
- Shared package eld_evt_pkg holds:
  - default widths (PEND_W_DEF=3, CNT_W_DEF=8)
  - SYNC_STAGES_DEF=2
  - localparam PEND_MAX function
- One sub-module is natural: toggle_sync_edge. It contains the SYNC_STAGES chain, the prev register and evt_pulse generation, with the reset-loads-input behaviour.
- Queue, counter and flag logic stay in the top level.

Test Plan:
1. Reset held low with tgl_in=1, then released → no evt_pulse, pend_cnt=0, evt_total=0 for 10 cycles.
2. Single toggle 0→1 with evt_ready=0 → evt_pulse high for one cycle, 2 edges after capture. pend_cnt=1, evt_valid=1 one edge later. evt_total=1.
3. 9 toggles spaced 3 cycles apart with evt_ready=0 (PEND_W=3) → pend_cnt saturates at 7 and overflow=1 after the 8th event. evt_total=9. Pulse clr_ovf → overflow=0, pend_cnt still 7.
4. pend_cnt=7 with evt_ready=1 on the same edge as the next evt_pulse → pend_cnt stays 7, overflow stays 0. Then drain with evt_ready=1 → count falls 7→0 in 7 cycles and evt_valid drops.
5. Free-running toggle every 4 cycles with evt_ready held 1 → pend_cnt alternates 0/1 and never exceeds 1. After 256 events evt_total wraps to 0, with no overflow.
6. clr_ovf and an overflowing event on the same edge → overflow=1. reset=0 mid-drain with pend_cnt=5 → next edge pend_cnt=0, evt_valid=0, evt_total=0.

Source files
------------

// File: rtl/eld_evt_pkg.sv
// Shared definitions for the toggle-flop event link (receive side).
// Holds default widths/depths and a helper that gives the largest pending count
// representable in a counter of a given width.
package eld_evt_pkg;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned PEND_W_DEF      = 3;
  localparam int unsigned CNT_W_DEF       = 8;

  // Saturation point of a pending-event counter of width w.
  function automatic int unsigned pend_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/toggle_sync_edge.sv
// Resynchronises a toggle line and emits a registered one-cycle pulse per level change.
// Ports:
//   clk_i    rising-edge clock
//   rst_ni   synchronous active-low reset; loads every stage with the live input
//   tgl_i    asynchronous toggle line
//   pulse_o  one-cycle pulse per detected level change (registered)
module toggle_sync_edge
  import eld_evt_pkg::*;
#(
  parameter int unsigned SyncStages = SYNC_STAGES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tgl_i,
  output logic pulse_o
);

  logic [SyncStages-1:0] sync_q, sync_d;
  logic                  prev_q;
  logic                  pulse_q;
  logic                  s;

  assign s = sync_q[SyncStages-1];

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = tgl_i;
    for (int i = 1; i < int'(SyncStages); i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Loading the live input on reset makes sync chain and prev agree, so the
  // first cycles after reset cannot see a phantom level change.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q  <= {SyncStages{tgl_i}};
      prev_q  <= tgl_i;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= s;
      pulse_q <= s ^ prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/toggle_event_rx.sv
// Receive side of the toggle-flop event link. Recovers one event per level change
// of tgl_in, queues events as a saturating pending count drained by valid/ready,
// keeps a wrapping total counter and a sticky overflow flag.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   tgl_in     toggle line from the sender's T flip-flop
//   evt_pulse  one-cycle pulse per detected toggle
//   evt_valid  at least one event pending (combinational from pend_cnt)
//   evt_ready  consumer takes one event when high with evt_valid
//   pend_cnt   pending event count, saturates at 2**PEND_W-1
//   evt_total  events detected since reset, wraps
//   overflow   sticky: an event was dropped on a full queue
//   clr_ovf    clears overflow (a coincident set wins)
module toggle_event_rx
  import eld_evt_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned PEND_W      = PEND_W_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tgl_in,
  output logic              evt_pulse,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [PEND_W-1:0] pend_cnt,
  output logic [CNT_W-1:0]  evt_total,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam logic [PEND_W-1:0] PendMax = PEND_W'(pend_max(PEND_W));

  logic              pulse;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic              ovf_q, ovf_d;
  logic              pop;
  logic              ovf_set;

  toggle_sync_edge #(
    .SyncStages(SYNC_STAGES)
  ) u_sync_edge (
    .clk_i  (clk),
    .rst_ni (reset),
    .tgl_i  (tgl_in),
    .pulse_o(pulse)
  );

  assign evt_valid = (pend_q != '0);
  assign pop       = evt_valid & evt_ready;

  always_comb begin
    pend_d  = pend_q;
    ovf_set = 1'b0;
    unique case ({pulse, pop})
      2'b10: begin
        if (pend_q == PendMax) ovf_set = 1'b1;
        else                   pend_d  = pend_q + 1'b1;
      end
      2'b01:   pend_d = pend_q - 1'b1;
      default: pend_d = pend_q;  // idle, or inc and pop cancel
    endcase

    total_d = pulse ? total_q + 1'b1 : total_q;

    if (ovf_set)      ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_q  <= '0;
      total_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      total_q <= total_d;
      ovf_q   <= ovf_d;
    end
  end

  assign evt_pulse = pulse;
  assign pend_cnt  = pend_q;
  assign evt_total = total_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_toggle_event_rx.sv
module tb_toggle_event_rx;

  localparam int unsigned PendW = 3;
  localparam int unsigned CntW  = 8;

  logic             clk;
  logic             reset;
  logic             tgl_in;
  logic             evt_pulse;
  logic             evt_valid;
  logic             evt_ready;
  logic [PendW-1:0] pend_cnt;
  logic [CntW-1:0]  evt_total;
  logic             overflow;
  logic             clr_ovf;

  int checks = 0;
  int errors = 0;
  int exp_total = 0;

  toggle_event_rx #(
    .SYNC_STAGES(2),
    .PEND_W     (PendW),
    .CNT_W      (CntW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tgl_in   (tgl_in),
    .evt_pulse(evt_pulse),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .pend_cnt (pend_cnt),
    .evt_total(evt_total),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset     = 1'b0;
    tgl_in    = 1'b1;
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;

    // 1: reset with tgl_in=1, then quiet after release
    tick(); tick(); tick();
    chk("rst_pulse", 32'(evt_pulse), 0);
    chk("rst_pend", 32'(pend_cnt), 0);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_total", 32'(evt_total), 0);
    chk("rst_ovf", 32'(overflow), 0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_pulse", 32'(evt_pulse), 0);
      chk("idle_pend", 32'(pend_cnt), 0);
    end
    chk("idle_total", 32'(evt_total), 0);

    // 2: single toggle, latency check
    tgl_in = ~tgl_in;
    tick();  // edge n: captured
    chk("lat_n0", 32'(evt_pulse), 0);
    tick();
    chk("lat_n1", 32'(evt_pulse), 0);
    tick();
    chk("lat_n2_pulse", 32'(evt_pulse), 1);
    chk("lat_n2_pend", 32'(pend_cnt), 0);
    tick();
    exp_total++;
    chk("lat_n3_pulse", 32'(evt_pulse), 0);
    chk("lat_n3_pend", 32'(pend_cnt), 1);
    chk("lat_n3_valid", 32'(evt_valid), 1);
    chk("lat_n3_total", 32'(evt_total), 1);

    // 3: events 2..9 spaced 3 cycles, no consumer -> saturation and overflow
    for (int k = 2; k <= 9; k++) begin
      tgl_in = ~tgl_in;
      tick(); tick(); tick();
      chk("sat_pulse", 32'(evt_pulse), 1);
      chk("sat_pend", 32'(pend_cnt), (k - 1 > 7) ? 7 : k - 1);
      chk("sat_ovf", 32'(overflow), (k - 1 >= 8) ? 1 : 0);
      chk("sat_total", 32'(evt_total), 32'(k - 1));
    end
    tick();
    exp_total = 9;
    chk("sat_end_pend", 32'(pend_cnt), 7);
    chk("sat_end_ovf", 32'(overflow), 1);
    chk("sat_end_total", 32'(evt_total), 9);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_pend", 32'(pend_cnt), 7);

    // 4: inc and pop together at max, then drain
    tgl_in = ~tgl_in;
    tick(); tick(); tick();
    chk("max_pop_pulse", 32'(evt_pulse), 1);
    evt_ready = 1'b1;
    tick();
    exp_total++;
    chk("max_pop_pend", 32'(pend_cnt), 7);
    chk("max_pop_ovf", 32'(overflow), 0);
    chk("max_pop_total", 32'(evt_total), 32'(exp_total));
    for (int i = 6; i >= 0; i--) begin
      tick();
      chk("drain_pend", 32'(pend_cnt), 32'(i));
    end
    chk("drain_valid", 32'(evt_valid), 0);
    tick();
    chk("drain_idle_pend", 32'(pend_cnt), 0);

    // 5: free-running toggles every 4 cycles with consumer always ready
    for (int k = 0; k < 246; k++) begin
      tgl_in = ~tgl_in;
      tick(); tick(); tick();
      chk("free_pend0", 32'(pend_cnt), 0);
      tick();
      exp_total++;
      chk("free_pend1", 32'(pend_cnt), 1);
      chk("free_total", 32'(evt_total), 32'(exp_total % 256));
    end
    tick();
    chk("wrap_pend", 32'(pend_cnt), 0);
    chk("wrap_total", 32'(evt_total), 0);
    chk("wrap_ovf", 32'(overflow), 0);

    // 6: fill, set/clear collision, then reset mid-drain
    evt_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tgl_in = ~tgl_in;
      tick(); tick(); tick();
    end
    tick();
    chk("fill_pend", 32'(pend_cnt), 7);
    tgl_in = ~tgl_in;
    tick(); tick(); tick();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("set_wins_ovf", 32'(overflow), 1);
    chk("set_wins_pend", 32'(pend_cnt), 7);
    chk("set_wins_total", 32'(evt_total), 8);
    evt_ready = 1'b1;
    tick(); tick();
    chk("pre_rst_pend", 32'(pend_cnt), 5);
    reset = 1'b0;
    tick();
    chk("mid_rst_pend", 32'(pend_cnt), 0);
    chk("mid_rst_valid", 32'(evt_valid), 0);
    chk("mid_rst_total", 32'(evt_total), 0);
    chk("mid_rst_ovf", 32'(overflow), 0);
    chk("mid_rst_pulse", 32'(evt_pulse), 0);
    reset = 1'b1;
    evt_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_pulse", 32'(evt_pulse), 0);
    end
    chk("post_rst_pend", 32'(pend_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
